// File: rtl/native_axil_bridge.sv
// Native valid/ready memory port to single-outstanding AXI4-lite master.
// Optional watchdog: define NATIVE_AXIL_BRIDGE_TIMEOUT_EN.
module native_axil_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  input  logic [1:0]  mem_axi_bresp,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  input  logic [1:0]  mem_axi_rresp,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic        bus_err
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_t;

  state_t      state, state_n;
  logic        aw_done, w_done, aw_done_n, w_done_n;
  logic [31:0] addr_q, addr_n;
  logic        arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n;
  logic [2:0]  arprot_n;
  logic [31:0] wdata_n, rdata_n, rd_count_n, wr_count_n;
  logic [3:0]  wstrb_n;
  logic        bus_err_n;
  logic        timeout;

  // One address register serves both channels: only one transaction is ever in flight.
  assign mem_axi_araddr = addr_q;
  assign mem_axi_awaddr = addr_q;
  assign mem_axi_awprot = 3'b000;
  assign mem_ready      = (state == DONE);

`ifdef NATIVE_AXIL_BRIDGE_TIMEOUT_EN
  logic [31:0] wdog, wdog_n;
  logic        busy;

  assign busy    = state inside {RD_ADDR, RD_DATA, WR_REQ, WR_RESP};
  assign timeout = busy && (wdog == TIMEOUT_CYCLES - 1);

  always_comb begin
    wdog_n = '0;
    if (state_n == state && busy) wdog_n = wdog + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) wdog <= '0;
    else     wdog <= wdog_n;
  end
`else
  // Watchdog compiled out; the parameter stays for a stable instantiation interface.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    arvalid_n  = mem_axi_arvalid;
    rready_n   = mem_axi_rready;
    awvalid_n  = mem_axi_awvalid;
    wvalid_n   = mem_axi_wvalid;
    bready_n   = mem_axi_bready;
    aw_done_n  = aw_done;
    w_done_n   = w_done;
    addr_n     = addr_q;
    arprot_n   = mem_axi_arprot;
    wdata_n    = mem_axi_wdata;
    wstrb_n    = mem_axi_wstrb;
    rdata_n    = mem_rdata;
    rd_count_n = rd_count;
    wr_count_n = wr_count;
    bus_err_n  = bus_err;
    case (state)
      IDLE: if (mem_valid) begin
        addr_n = mem_addr;
        if (mem_wstrb == 4'b0000) begin
          arprot_n  = {mem_instr, 2'b00};
          arvalid_n = 1'b1;
          state_n   = RD_ADDR;
        end else begin
          wdata_n   = mem_wdata;
          wstrb_n   = mem_wstrb;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = WR_REQ;
        end
      end
      RD_ADDR: if (mem_axi_arvalid && mem_axi_arready) begin
        arvalid_n = 1'b0;
        rready_n  = 1'b1;
        state_n   = RD_DATA;
      end
      RD_DATA: if (mem_axi_rvalid && mem_axi_rready) begin
        rdata_n    = mem_axi_rdata;
        rready_n   = 1'b0;
        rd_count_n = rd_count + 32'd1;
        bus_err_n  = bus_err | (mem_axi_rresp != 2'b00);
        state_n    = DONE;
      end
      WR_REQ: begin
        if (mem_axi_awvalid && mem_axi_awready) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (mem_axi_wvalid && mem_axi_wready) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        // Uses the next-state flags so a same-cycle AW+W handshake advances at once.
        if (aw_done_n && w_done_n) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: if (mem_axi_bvalid && mem_axi_bready) begin
        bready_n   = 1'b0;
        wr_count_n = wr_count + 32'd1;
        bus_err_n  = bus_err | (mem_axi_bresp != 2'b00);
        state_n    = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (timeout) begin
      arvalid_n  = 1'b0;
      rready_n   = 1'b0;
      awvalid_n  = 1'b0;
      wvalid_n   = 1'b0;
      bready_n   = 1'b0;
      bus_err_n  = 1'b1;
      rd_count_n = rd_count;
      wr_count_n = wr_count;
      if (state == RD_ADDR || state == RD_DATA) rdata_n = ERR_RDATA;
      state_n = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      mem_axi_arvalid <= 1'b0;
      mem_axi_rready  <= 1'b0;
      mem_axi_awvalid <= 1'b0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_bready  <= 1'b0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      addr_q          <= '0;
      mem_axi_arprot  <= '0;
      mem_axi_wdata   <= '0;
      mem_axi_wstrb   <= '0;
      mem_rdata       <= '0;
      rd_count        <= '0;
      wr_count        <= '0;
      bus_err         <= 1'b0;
    end else begin
      state           <= state_n;
      mem_axi_arvalid <= arvalid_n;
      mem_axi_rready  <= rready_n;
      mem_axi_awvalid <= awvalid_n;
      mem_axi_wvalid  <= wvalid_n;
      mem_axi_bready  <= bready_n;
      aw_done         <= aw_done_n;
      w_done          <= w_done_n;
      addr_q          <= addr_n;
      mem_axi_arprot  <= arprot_n;
      mem_axi_wdata   <= wdata_n;
      mem_axi_wstrb   <= wstrb_n;
      mem_rdata       <= rdata_n;
      rd_count        <= rd_count_n;
      wr_count        <= wr_count_n;
      bus_err         <= bus_err_n;
    end
  end

endmodule

// File: tb/tb_native_axil_bridge.sv
// Self-checking bench for native_axil_bridge: behavioural AXI-lite slave with
// per-channel latency knobs, plus a transaction-level reference model.
module tb_native_axil_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [31:0] rd_count, wr_count;
  logic        bus_err;

  native_axil_bridge #(.TIMEOUT_CYCLES(16), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata), .mem_axi_rresp(rresp),
    .rd_count(rd_count), .wr_count(wr_count), .bus_err(bus_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Address pool; each entry owns one word in slave and reference memories.
  logic [31:0] pool [0:7] = '{32'h0000_0010, 32'h0000_0000, 32'h1000_0000, 32'hF000_0000,
                              32'h0000_0020, 32'h1000_0004, 32'h1000_0001, 32'hF000_0008};

  function automatic int slot(input logic [31:0] a);
    for (int i = 0; i < 8; i++) if (pool[i] == a) return i;
    return 0;
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a == 32'h10) ? 32'h1234_5678 : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [1:0] resp_for(input logic [31:0] a);
    return (a[31:28] == 4'hF) ? 2'b10 : 2'b00;
  endfunction

  // ---------------- behavioural AXI-lite slave ----------------
  int unsigned ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  bit          r_never = 1'b0;
  int unsigned ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
  bit          r_pend = 1'b0, b_pend = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] slave_mem [0:7];
  int          ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0;
  logic [31:0] ar_addr_seen = '0, aw_addr_seen = '0, w_data_seen = '0;
  logic [2:0]  ar_prot_seen = '0, aw_prot_seen = '0;
  logic [3:0]  w_strb_seen = '0;
  logic        ar_hs, aw_hs, w_hs, wr_commit;
  logic [31:0] wa_eff, wd_eff;
  logic [3:0]  ws_eff;

  assign arready   = (ar_cnt >= ar_lat);
  assign awready   = (aw_cnt >= aw_lat);
  assign wready    = (w_cnt >= w_lat);
  assign ar_hs     = arvalid & arready;
  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign wr_commit = (aw_got | aw_hs) & (w_got | w_hs);
  assign wa_eff    = aw_hs ? awaddr : aw_addr_seen;
  assign wd_eff    = w_hs ? wdata : w_data_seen;
  assign ws_eff    = w_hs ? wstrb : w_strb_seen;

  always @(posedge clk) begin
    if (rst) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
      r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      rvalid <= 1'b0; bvalid <= 1'b0; rdata <= '0; rresp <= '0; bresp <= '0;
      for (int i = 0; i < 8; i++) slave_mem[i] <= init_word(pool[i]);
    end else begin
      ar_cnt <= (arvalid && !ar_hs) ? ar_cnt + 1 : 0;
      aw_cnt <= (awvalid && !aw_hs) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !w_hs) ? w_cnt + 1 : 0;
      if (rvalid && rready) rvalid <= 1'b0;
      if (bvalid && bready) bvalid <= 1'b0;
      if (ar_hs) begin
        ar_hs_n      <= ar_hs_n + 1;
        ar_addr_seen <= araddr;
        ar_prot_seen <= arprot;
        rdata        <= slave_mem[slot(araddr)];
        rresp        <= resp_for(araddr);
        if (!r_never) begin
          if (r_lat == 0) rvalid <= 1'b1;
          else begin r_pend <= 1'b1; r_cnt <= r_lat; end
        end
      end else if (r_pend) begin
        if (r_cnt == 1) begin rvalid <= 1'b1; r_pend <= 1'b0; end
        r_cnt <= r_cnt - 1;
      end
      if (aw_hs) begin
        aw_hs_n <= aw_hs_n + 1; aw_addr_seen <= awaddr; aw_prot_seen <= awprot; aw_got <= 1'b1;
      end
      if (w_hs) begin
        w_hs_n <= w_hs_n + 1; w_data_seen <= wdata; w_strb_seen <= wstrb; w_got <= 1'b1;
      end
      if (wr_commit) begin
        slave_mem[slot(wa_eff)] <= merge(slave_mem[slot(wa_eff)], wd_eff, ws_eff);
        bresp  <= resp_for(wa_eff);
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (b_lat == 0) bvalid <= 1'b1;
        else begin b_pend <= 1'b1; b_cnt <= b_lat; end
      end else if (b_pend) begin
        if (b_cnt == 1) begin bvalid <= 1'b1; b_pend <= 1'b0; end
        b_cnt <= b_cnt - 1;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:7];
  logic [31:0] exp_rd = '0, exp_wr = '0;
  logic        exp_err = 1'b0;

  task automatic do_reset(input int n);
    rst = 1'b1;
    mem_valid = 1'b0;
    mem_wstrb = '0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_rd = '0; exp_wr = '0; exp_err = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[i] = init_word(pool[i]);
  endtask

  task automatic set_lat(input int unsigned a, input int unsigned r, input int unsigned aw,
                         input int unsigned w, input int unsigned b);
    ar_lat = a; r_lat = r; aw_lat = aw; w_lat = w; b_lat = b;
  endtask

  // Starts and ends on a negedge.
  task automatic run_txn(input logic instr, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] strb);
    int          ar0, aw0, w0, s;
    int unsigned lat, exp_lat;
    bit          seen, rd;
    logic [31:0] exp_data;
    ar0 = ar_hs_n; aw0 = aw_hs_n; w0 = w_hs_n;
    s = slot(addr);
    rd = (strb == 4'b0000);
    exp_data = ref_mem[s];
    if (rd) begin
      exp_lat = 3 + ar_lat + r_lat;
      exp_rd  = exp_rd + 32'd1;
    end else begin
      exp_lat  = 3 + ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat;
      ref_mem[s] = merge(ref_mem[s], wd, strb);
      exp_wr   = exp_wr + 32'd1;
    end
    if (addr[31:28] == 4'hF) exp_err = 1'b1;
    mem_valid = 1'b1; mem_instr = instr; mem_addr = addr; mem_wdata = wd; mem_wstrb = strb;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (mem_ready) seen = 1'b1;
    end
    mem_valid = 1'b0; mem_wstrb = '0;
    check("ready_seen", 32'(seen), 32'd1);
    check("latency", lat, exp_lat);
    if (rd) begin
      check("rdata", mem_rdata, exp_data);
      check("ar_count", 32'(ar_hs_n - ar0), 32'd1);
      check("araddr", ar_addr_seen, addr);
      check("arprot", 32'(ar_prot_seen), 32'({instr, 2'b00}));
    end else begin
      check("aw_count", 32'(aw_hs_n - aw0), 32'd1);
      check("w_count", 32'(w_hs_n - w0), 32'd1);
      check("awaddr", aw_addr_seen, addr);
      check("awprot", 32'(aw_prot_seen), 32'd0);
      check("wdata", w_data_seen, wd);
      check("wstrb", 32'(w_strb_seen), 32'(strb));
    end
    check("rd_count", rd_count, exp_rd);
    check("wr_count", wr_count, exp_wr);
    check("bus_err", 32'(bus_err), 32'(exp_err));
    @(posedge clk);
    @(negedge clk);
    check("ready_pulse", 32'(mem_ready), 32'd0);
  endtask

  initial begin
    int          n_ready;
    int unsigned idx;
    logic [3:0]  strb;

    do_reset(3);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_mem_ready", 32'(mem_ready), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_rd_count", rd_count, 32'd0);
    check("rst_wr_count", wr_count, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);

    // Reset in the middle of a stalled write.
    set_lat(0, 0, 20, 20, 0);
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h1000_0004; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
    @(posedge clk); @(negedge clk);
    check("mid_awvalid", 32'(awvalid), 32'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1; mem_valid = 1'b0; mem_wstrb = '0;
    @(posedge clk); @(negedge clk);
    check("mid_rst_awvalid", 32'(awvalid), 32'd0);
    check("mid_rst_wvalid", 32'(wvalid), 32'd0);
    check("mid_rst_arvalid", 32'(arvalid), 32'd0);
    check("mid_rst_bready", 32'(bready), 32'd0);
    rst = 1'b0;
    exp_rd = '0; exp_wr = '0; exp_err = 1'b0;
    for (int i = 0; i < 8; i++) ref_mem[i] = init_word(pool[i]);
    n_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (mem_ready) n_ready++;
    end
    check("mid_no_ready", 32'(n_ready), 32'd0);
    check("mid_rd_count", rd_count, 32'd0);
    check("mid_wr_count", wr_count, 32'd0);

    set_lat(0, 0, 0, 0, 0);
    run_txn(1'b0, 32'h0000_0020, '0, 4'b0000);
    run_txn(1'b0, 32'h0000_0010, '0, 4'b0000);
    run_txn(1'b1, 32'h0000_0000, '0, 4'b0000);
    set_lat(0, 0, 2, 0, 0);
    run_txn(1'b0, 32'h1000_0000, 32'h0000_0041, 4'b0001);
    set_lat(0, 0, 0, 0, 0);
    run_txn(1'b0, 32'hF000_0000, 32'h5555_AAAA, 4'b1111);
    run_txn(1'b0, 32'h1000_0000, '0, 4'b0000);
    set_lat(0, 0, 0, 2, 1);
    run_txn(1'b0, 32'h1000_0001, 32'hCAFE_F00D, 4'b0110);

    for (int i = 0; i < 40; i++) begin
      set_lat($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      idx  = $urandom_range(0, 7);
      strb = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      run_txn(1'($urandom_range(0, 1)), pool[idx], $urandom, strb);
    end

`ifdef NATIVE_AXIL_BRIDGE_TIMEOUT_EN
    begin
      int unsigned lat;
      do_reset(2);
      set_lat(0, 0, 0, 0, 0);
      r_never = 1'b1;
      mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0000_0010; mem_wstrb = 4'b0000;
      lat = 0; n_ready = 0;
      while (n_ready == 0 && lat < 200) begin
        @(posedge clk); lat++;
        @(negedge clk);
        if (mem_ready) n_ready = 1;
      end
      mem_valid = 1'b0;
      check("to_latency", lat, 32'd18);
      check("to_rdata", mem_rdata, 32'hDEAD_BEEF);
      check("to_bus_err", 32'(bus_err), 32'd1);
      check("to_rd_count", rd_count, 32'd0);
      check("to_rready", 32'(rready), 32'd0);
      r_never = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
